// File: rtl/conv_window_buffer.sv
// ---------------------------------------------------------------------------
// conv_window_buffer
//
// Sliding-window row buffer feeding the MAC array for convolution layers.
// It holds R = OUT_ROWS+K-1 image rows. It steps through all K*K kernel taps
// and presents one OUT_ROWS x OW pixel slice per tap (OW = IMG_W-K+1). It then
// drops the oldest OUT_ROWS rows and refills from the stream for the next sweep.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         begin a frame (sampled only while idle)
//   cfg_blocks    number of sweeps in the frame, latched on start
//   in_valid      input row handshake: valid
//   in_ready      input row handshake: ready
//   in_row        one image row, pixel c at [c*DW +: DW]
//   out_valid     slice handshake: valid
//   out_ready     slice handshake: ready
//   out_data      slice, element (o,x) at [(o*OW+x)*DW +: DW]
//   out_ker_row   kernel row of the current tap
//   out_ker_col   kernel column of the current tap
//   out_last      final tap (K-1,K-1) of a sweep
//   busy          frame in progress
//   done          one-cycle pulse when the frame completes
// ---------------------------------------------------------------------------
module conv_window_buffer #(
    parameter int DW       = 16,
    parameter int IMG_W    = 32,
    parameter int K        = 5,
    parameter int OUT_ROWS = 4,
    parameter int BLK_W    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [BLK_W-1:0]                      cfg_blocks,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [IMG_W*DW-1:0]                   in_row,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_ROWS*(IMG_W-K+1)*DW-1:0]    out_data,
    output logic [3:0]                            out_ker_row,
    output logic [3:0]                            out_ker_col,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int OW = IMG_W - K + 1;
    localparam int R  = OUT_ROWS + K - 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SWEEP,
        SLIDE
    } state_t;

    state_t state;
    state_t next_state;

    logic [IMG_W*DW-1:0] rows [R];
    logic [RW-1:0]       fill_cnt;
    logic [KW-1:0]       ker_row;
    logic [KW-1:0]       ker_col;
    logic [BLK_W-1:0]    blk_left;
    logic                shift_pending;

    logic                in_fire;
    logic                out_fire;
    logic                last_tap;
    logic                row_full;

    logic [RW-1:0]       ridx;
    logic [IMG_W*DW-1:0] sel_row;

    assign last_tap    = (ker_row == KW'(K-1)) && (ker_col == KW'(K-1));
    assign row_full    = (fill_cnt == RW'(R-1));
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign out_ker_row = 4'(ker_row);
    assign out_ker_col = 4'(ker_col);

    // State register. Reset always returns to IDLE, so an interrupted frame
    // is abandoned rather than resumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. in_ready stays low on the first SLIDE
    // cycle because that cycle shifts the kept rows down. A row written then
    // would collide with the shift.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && (cfg_blocks != '0)) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && row_full) begin
                    next_state = SWEEP;
                end
            end
            SWEEP: begin
                out_valid = 1'b1;
                out_last  = last_tap;
                if (out_ready && last_tap) begin
                    next_state = (blk_left == BLK_W'(1)) ? IDLE : SLIDE;
                end
            end
            SLIDE: begin
                in_ready = !shift_pending;
                if (in_valid && !shift_pending && row_full) begin
                    next_state = SWEEP;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Row store, fill counter, tap counters and sweep bookkeeping. Between
    // sweeps, rows OUT_ROWS..R-1 move to 0..K-2 in one cycle. The remaining
    // OUT_ROWS slots at the bottom then refill from the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                rows[RW'(i)] <= '0;
            end
            fill_cnt      <= '0;
            ker_row       <= '0;
            ker_col       <= '0;
            blk_left      <= '0;
            shift_pending <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_blocks != '0) begin
                            blk_left <= cfg_blocks;
                            fill_cnt <= '0;
                            ker_row  <= '0;
                            ker_col  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_fire) begin
                        rows[fill_cnt] <= in_row;
                        fill_cnt       <= row_full ? '0 : fill_cnt + RW'(1);
                    end
                end
                SWEEP: begin
                    if (out_fire) begin
                        if (ker_col == KW'(K-1)) begin
                            ker_col <= '0;
                            ker_row <= (ker_row == KW'(K-1)) ? '0 : ker_row + KW'(1);
                        end else begin
                            ker_col <= ker_col + KW'(1);
                        end
                        if (last_tap) begin
                            blk_left <= blk_left - BLK_W'(1);
                            if (blk_left == BLK_W'(1)) begin
                                done <= 1'b1;
                            end else begin
                                fill_cnt      <= RW'(K-1);
                                shift_pending <= 1'b1;
                            end
                        end
                    end
                end
                SLIDE: begin
                    if (shift_pending) begin
                        for (int i = 0; i < K-1; i++) begin
                            rows[RW'(i)] <= rows[RW'(i + OUT_ROWS)];
                        end
                        shift_pending <= 1'b0;
                    end else if (in_fire) begin
                        rows[fill_cnt] <= in_row;
                        fill_cnt       <= row_full ? '0 : fill_cnt + RW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice selection. Element (o,x) of the current tap comes from row
    // o+ker_row, pixel x+ker_col. The slice is purely combinational, so it
    // holds steady whenever the tap counters hold.
    always_comb begin
        out_data = '0;
        ridx     = '0;
        sel_row  = '0;
        for (int o = 0; o < OUT_ROWS; o++) begin
            ridx    = RW'(o) + RW'(ker_row);
            sel_row = rows[ridx];
            for (int x = 0; x < OW; x++) begin
                out_data[(o*OW + x)*DW +: DW] = sel_row[(x + int'(ker_col))*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_buffer
//
// Directed bench for conv_window_buffer with IMG_W=8, K=3, OUT_ROWS=2
// (OW=6, R=4) and 8-bit pixels. Pixel (r,c) of the streamed image is r*16+c.
// The expected slice for sweep s and tap (kr,kc) therefore has element (o,x)
// equal to (2s+o+kr)*16 + (x+kc).
// ---------------------------------------------------------------------------
module tb_conv_window_buffer;

    localparam int DW       = 8;
    localparam int IMG_W    = 8;
    localparam int K        = 3;
    localparam int OUT_ROWS = 2;
    localparam int BLK_W    = 8;
    localparam int OW       = IMG_W - K + 1;
    localparam int R        = OUT_ROWS + K - 1;
    localparam int SW       = OUT_ROWS * OW * DW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [BLK_W-1:0]       cfg_blocks = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [IMG_W*DW-1:0]    in_row = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [SW-1:0]          out_data;
    logic [3:0]             out_ker_row;
    logic [3:0]             out_ker_col;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    logic [7:0] first_e00 [4];
    logic [7:0] last_e15  [4];

    conv_window_buffer #(
        .DW       (DW),
        .IMG_W    (IMG_W),
        .K        (K),
        .OUT_ROWS (OUT_ROWS),
        .BLK_W    (BLK_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_blocks  (cfg_blocks),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ker_row (out_ker_row),
        .out_ker_col (out_ker_col),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [SW-1:0] observed,
                               input logic [SW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [IMG_W*DW-1:0] makeRow(input int r);
        logic [IMG_W*DW-1:0] v;
        v = '0;
        for (int c = 0; c < IMG_W; c++) begin
            v[c*DW +: DW] = 8'(r*16 + c);
        end
        return v;
    endfunction

    function automatic logic [SW-1:0] modelSlice(input int s, input int kr, input int kc);
        logic [SW-1:0] v;
        v = '0;
        for (int o = 0; o < OUT_ROWS; o++) begin
            for (int x = 0; x < OW; x++) begin
                v[(o*OW + x)*DW +: DW] = 8'((s*OUT_ROWS + o + kr)*16 + x + kc);
            end
        end
        return v;
    endfunction

    // Synchronous reset pulse followed by checks of the idle outputs.
    task automatic resetDut();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_data", out_data, 0);
        rst = 1'b0;
    endtask

    // Runs one frame of nb sweeps. It streams rows with optional gaps, stalls
    // out_ready at random and checks every tap against the pixel model.
    // late_start pulses start mid-sweep, which the DUT must ignore. abort_en
    // resets the DUT at tap (1,1) of sweep 2.
    task automatic applyStimulus(input int nb, input int gap_pct, input int stall_pct,
                                 input bit late_start, input bit abort_en);
        int nrows;
        int row_idx;
        int sweep;
        int kr;
        int kc;
        int taps;
        int cyc;
        bit exp_done;
        bit exp_valid_next;
        bit finished;
        bit prev_stall;
        bit aborted;
        logic [SW-1:0] prev_data;

        nrows = R + (nb - 1)*OUT_ROWS;
        row_idx = 0; sweep = 0; kr = 0; kc = 0; taps = 0; cyc = 0;
        exp_done = 0; exp_valid_next = 0; finished = 0; prev_stall = 0; aborted = 0;
        prev_data = '0;
        for (int i = 0; i < 4; i++) begin
            first_e00[i] = 8'hFF;
            last_e15[i]  = 8'hFF;
        end

        @(negedge clk);
        start = 1'b1;
        cfg_blocks = 8'(nb);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        while (!finished && cyc < 3000) begin
            cyc++;
            checkOutput("done", done, exp_done);
            if (exp_done) begin
                checkOutput("busy_end", busy, 0);
                finished = 1;
            end else begin
                if (exp_valid_next) begin
                    checkOutput("latency", out_valid, 1);
                end
                if (out_valid) begin
                    checkOutput("in_ready_sweep", in_ready, 0);
                    checkOutput("tap_row", out_ker_row, kr);
                    checkOutput("tap_col", out_ker_col, kc);
                    checkOutput("last", out_last, (kr == K-1 && kc == K-1));
                    checkOutput("slice", out_data, modelSlice(sweep, kr, kc));
                    if (prev_stall) begin
                        checkOutput("stall_hold", out_data, prev_data);
                    end
                    if (kr == 0 && kc == 0) first_e00[sweep] = out_data[7:0];
                    if (kr == K-1 && kc == K-1) last_e15[sweep] = out_data[SW-1 -: 8];
                end
            end
            exp_done = 0;
            exp_valid_next = 0;

            if (!finished && abort_en && out_valid && sweep == 1 && kr == 1 && kc == 1) begin
                rst = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
                start = 1'b0;
                @(negedge clk);
                checkOutput("abort_out_valid", out_valid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_data", out_data, 0);
                checkOutput("abort_in_ready", in_ready, 0);
                checkOutput("abort_tap", {out_ker_row, out_ker_col}, 0);
                rst = 1'b0;
                aborted = 1;
                finished = 1;
            end

            if (!finished) begin
                in_valid = (row_idx < nrows) && ($urandom_range(99) >= gap_pct);
                in_row = makeRow(row_idx);
                out_ready = ($urandom_range(99) >= stall_pct);
                start = late_start && out_valid && sweep == 0 && kr == 0 && kc == 1;
                if (start) cfg_blocks = 8'd5;

                if (in_valid && in_ready) begin
                    row_idx++;
                    if (row_idx == R || (row_idx > R && (row_idx - R) % OUT_ROWS == 0)) begin
                        exp_valid_next = 1;
                    end
                end
                if (out_valid && out_ready) begin
                    taps++;
                    prev_stall = 0;
                    if (kc == K-1) begin
                        kc = 0;
                        if (kr == K-1) begin
                            kr = 0;
                            sweep++;
                        end else begin
                            kr++;
                        end
                    end else begin
                        kc++;
                    end
                    if (taps == nb*K*K) exp_done = 1;
                end else begin
                    prev_stall = out_valid;
                end
                prev_data = out_data;
                @(negedge clk);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!finished) checkOutput("timeout", 0, 1);
        if (abort_en) checkOutput("abort_hit", aborted, 1);
        else checkOutput("tap_count", taps, nb*K*K);
    endtask

    initial begin
        resetDut();

        // Single sweep, back-to-back rows, no stalls.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("s1_first_e00", first_e00[0], 8'h00);
        checkOutput("s1_last_e15", last_e15[0], 8'h37);

        // Three sweeps, streamed.
        applyStimulus(3, 0, 0, 0, 0);
        checkOutput("s2_first_e00", first_e00[1], 8'h20);
        checkOutput("s2_last_e15", last_e15[2], 8'h77);

        // Random output back-pressure.
        applyStimulus(3, 0, 50, 0, 0);
        checkOutput("s3_first_e00", first_e00[1], 8'h20);
        checkOutput("s3_last_e15", last_e15[2], 8'h77);

        // Input gaps, plus a start pulse during SWEEP that must be ignored.
        applyStimulus(3, 40, 20, 1, 0);
        checkOutput("s4_first_e00", first_e00[1], 8'h20);
        checkOutput("s4_last_e15", last_e15[2], 8'h77);

        // Reset mid-sweep, then a clean frame afterwards.
        applyStimulus(3, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("s5_first_e00", first_e00[0], 8'h00);
        checkOutput("s5_last_e15", last_e15[0], 8'h37);

        // Zero-sweep frame: immediate done, no handshakes.
        @(negedge clk);
        start = 1'b1;
        cfg_blocks = 8'd0;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_in_ready", in_ready, 0);
        checkOutput("zero_out_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("zero_done_pulse", done, 0);
        checkOutput("zero_idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
